// File: rtl/vend_change_dispenser_if.sv
// ---------------------------------------------------------------------------
// vend_change_dispenser_if : request, refill, sensor and actuator signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vend_change_dispenser_if #(
  parameter int INV_W = 6
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       cash_return;
  logic             purchase;
  logic             refill_valid;
  logic [INV_W-1:0] refill_5;
  logic [INV_W-1:0] refill_10;
  logic             coin_sensed;
  logic             eject_5;
  logic             eject_10;
  logic             product_release;
  logic             busy;
  logic             fault;
  logic [INV_W-1:0] inv_5;
  logic [INV_W-1:0] inv_10;

  modport master (
    output req_valid, cash_return, purchase, refill_valid, refill_5, refill_10, coin_sensed,
    input  req_ready, eject_5, eject_10, product_release, busy, fault, inv_5, inv_10
  );

  modport slave (
    input  req_valid, cash_return, purchase, refill_valid, refill_5, refill_10, coin_sensed,
    output req_ready, eject_5, eject_10, product_release, busy, fault, inv_5, inv_10
  );
endinterface

`default_nettype wire

// File: rtl/vend_change_dispenser.sv
// ---------------------------------------------------------------------------
// vend_change_dispenser : coin ejector / product release sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vend_change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int TIMEOUT      = 16,
  parameter int INV_W        = 6,
  parameter int INIT_5       = 10,
  parameter int INIT_10      = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  vend_change_dispenser_if.slave  bus
);

  localparam int c_CNT_MAX = (TIMEOUT > PULSE_CYCLES)
                           ? ((TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES)
                           : ((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES);
  localparam int CNT_W = $clog2(c_CNT_MAX + 1);

  localparam logic [CNT_W-1:0] c_PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [INV_W-1:0] c_INIT_5       = INV_W'(INIT_5);
  localparam logic [INV_W-1:0] c_INIT_10      = INV_W'(INIT_10);
  localparam logic [INV_W-1:0] c_ONE          = INV_W'(1);
  localparam logic [INV_W-1:0] c_TWO          = INV_W'(2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAN  = 3'd1,
    S_EJECT = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_VEND  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       code_q, code_d;
  logic             purch_q, purch_d;
  logic [1:0]       coins_q, coins_d;
  logic             is10_q, is10_d;
  logic [INV_W-1:0] inv5_q, inv5_d;
  logic [INV_W-1:0] inv10_q, inv10_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic             e5_q, e5_d;
  logic             e10_q, e10_d;
  logic             rel_q, rel_d;

  logic [INV_W:0]   w_sum5;
  logic [INV_W:0]   w_sum10;

  assign w_sum5  = {1'b0, inv5_q} + {1'b0, bus.refill_5};
  assign w_sum10 = {1'b0, inv10_q} + {1'b0, bus.refill_10};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    purch_d = purch_q;
    coins_d = coins_q;
    is10_d  = is10_q;
    inv5_d  = inv5_q;
    inv10_d = inv10_q;

    case (state_q)
      S_IDLE: begin
        if (bus.refill_valid) begin
          inv5_d  = w_sum5[INV_W]  ? '1 : w_sum5[INV_W-1:0];
          inv10_d = w_sum10[INV_W] ? '1 : w_sum10[INV_W-1:0];
        end
        if (bus.req_valid && ready_q) begin
          code_d  = bus.cash_return;
          purch_d = bus.purchase;
          cnt_d   = '0;
          state_d = S_PLAN;
        end
      end
      S_PLAN: begin
        // The coin list is always homogeneous: one 10, one 5, or two 5s.
        cnt_d   = '0;
        coins_d = 2'd0;
        is10_d  = 1'b0;
        state_d = purch_q ? S_VEND : S_IDLE;
        case (code_q)
          2'b00: ;
          2'b01: begin
            if (inv5_q >= c_ONE) begin
              coins_d = 2'd1;
              state_d = S_EJECT;
            end else begin
              state_d = S_FAULT;
            end
          end
          2'b10: begin
            if (inv10_q >= c_ONE) begin
              coins_d = 2'd1;
              is10_d  = 1'b1;
              state_d = S_EJECT;
            end else if (inv5_q >= c_TWO) begin
              coins_d = 2'd2;
              state_d = S_EJECT;
            end else begin
              state_d = S_FAULT;
            end
          end
          default: state_d = S_FAULT;
        endcase
      end
      S_EJECT: begin
        if (cnt_q == c_PULSE_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (bus.coin_sensed) begin
          if (is10_q) inv10_d = inv10_q - c_ONE;
          else        inv5_d  = inv5_q - c_ONE;
          coins_d = coins_q - 2'd1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt_q == c_TIMEOUT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == c_GAP_LAST) begin
          cnt_d = '0;
          if (coins_q != 2'd0) state_d = S_EJECT;
          else if (purch_q)    state_d = S_VEND;
          else                 state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_VEND: begin
        if (cnt_q == c_PULSE_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    // Outputs are decoded from the next state so they appear registered.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE) && (state_d != S_FAULT);
    fault_d = (state_d == S_FAULT);
    e5_d    = (state_d == S_EJECT) && !is10_d;
    e10_d   = (state_d == S_EJECT) && is10_d;
    rel_d   = (state_d == S_VEND);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      code_q  <= 2'b00;
      purch_q <= 1'b0;
      coins_q <= 2'd0;
      is10_q  <= 1'b0;
      inv5_q  <= c_INIT_5;
      inv10_q <= c_INIT_10;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      e5_q    <= 1'b0;
      e10_q   <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      purch_q <= purch_d;
      coins_q <= coins_d;
      is10_q  <= is10_d;
      inv5_q  <= inv5_d;
      inv10_q <= inv10_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      e5_q    <= e5_d;
      e10_q   <= e10_d;
      rel_q   <= rel_d;
    end
  end

  assign bus.req_ready       = ready_q;
  assign bus.busy            = busy_q;
  assign bus.fault           = fault_q;
  assign bus.eject_5         = e5_q;
  assign bus.eject_10        = e10_q;
  assign bus.product_release = rel_q;
  assign bus.inv_5           = inv5_q;
  assign bus.inv_10          = inv10_q;

endmodule

`default_nettype wire

// File: tb/tb_vend_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_vend_change_dispenser : directed self-checking bench for the dispenser
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vend_change_dispenser;

  localparam int PULSE = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  vend_change_dispenser_if #(.INV_W(6)) u_bus ();

  vend_change_dispenser #(
    .PULSE_CYCLES (4),
    .GAP_CYCLES   (2),
    .TIMEOUT      (16),
    .INV_W        (6),
    .INIT_5       (10),
    .INIT_10      (10)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issues one request and watches the actuators until the dispenser is idle or faulted.
  task automatic run_txn(input logic [1:0] code, input logic purch, input logic sense,
                         output int n5, output int n10, output int nrel, output int bad_w,
                         output int min_gap, output int wait_len, output int overlap,
                         output int done);
    int   w;
    int   rw;
    int   gap;
    logic pe;
    logic prel;
    logic e;
    logic seen_fall;
    n5 = 0; n10 = 0; nrel = 0; bad_w = 0; min_gap = 1000; wait_len = 0; overlap = 0; done = 0;
    w = 0; rw = 0; gap = 0; pe = 1'b0; prel = 1'b0; seen_fall = 1'b0;
    u_bus.req_valid   = 1'b1;
    u_bus.cash_return = code;
    u_bus.purchase    = purch;
    tick();
    u_bus.req_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      u_bus.coin_sensed = 1'b0;
      e = u_bus.eject_5 | u_bus.eject_10;
      if ((u_bus.eject_5 & u_bus.eject_10) | (e & u_bus.product_release)) overlap = 1;
      if (e) begin
        if (!pe) begin
          if (seen_fall && gap < min_gap) min_gap = gap;
          if (u_bus.eject_5) n5++;
          else               n10++;
        end
        w++;
      end else begin
        if (pe) begin
          if (w != PULSE) bad_w++;
          w = 0;
          gap = 0;
          wait_len = 0;
          seen_fall = 1'b1;
          if (sense) u_bus.coin_sensed = 1'b1;
        end
        gap++;
        if (!u_bus.fault) wait_len++;
      end
      if (u_bus.product_release) begin
        if (!prel) nrel++;
        rw++;
      end else if (prel) begin
        if (rw != PULSE) bad_w++;
        rw = 0;
      end
      if (u_bus.req_ready || u_bus.fault) begin
        done = 1;
        break;
      end
      pe   = e;
      prel = u_bus.product_release;
      tick();
    end
    u_bus.coin_sensed = 1'b0;
  endtask

  initial begin
    int n5, n10, nrel, bad_w, min_gap, wait_len, overlap, done;
    int sum10, sum5, bad, alldone;
    logic flag;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    u_bus.req_valid    = 1'b0;
    u_bus.cash_return  = 2'b00;
    u_bus.purchase     = 1'b0;
    u_bus.refill_valid = 1'b0;
    u_bus.refill_5     = '0;
    u_bus.refill_10    = '0;
    u_bus.coin_sensed  = 1'b0;

    // Reset state
    do_reset();
    chk("rst_ready", u_bus.req_ready, 1);
    chk("rst_busy",  u_bus.busy, 0);
    chk("rst_fault", u_bus.fault, 0);
    chk("rst_ej",    {u_bus.eject_5, u_bus.eject_10, u_bus.product_release}, 0);
    chk("rst_inv5",  u_bus.inv_5, 10);
    chk("rst_inv10", u_bus.inv_10, 10);

    // R10 + purchase, cycle by cycle
    u_bus.req_valid = 1'b1; u_bus.cash_return = 2'b10; u_bus.purchase = 1'b1;
    tick();
    u_bus.req_valid = 1'b0;
    chk("s1_plan_ready", u_bus.req_ready, 0);
    chk("s1_plan_busy",  u_bus.busy, 1);
    chk("s1_plan_ej10",  u_bus.eject_10, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("s1_ej10_hi", {u_bus.eject_10, u_bus.eject_5}, 2'b10);
      tick();
    end
    chk("s1_ej10_lo", u_bus.eject_10, 0);
    u_bus.coin_sensed = 1'b1;
    tick();
    u_bus.coin_sensed = 1'b0;
    chk("s1_inv10", u_bus.inv_10, 9);
    chk("s1_gap0_rel", u_bus.product_release, 0);
    tick();
    chk("s1_gap1_rel", u_bus.product_release, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("s1_rel_hi", u_bus.product_release, 1);
      tick();
    end
    chk("s1_rel_lo", u_bus.product_release, 0);
    chk("s1_ready",  u_bus.req_ready, 1);
    chk("s1_busy",   u_bus.busy, 0);

    // Drain 10tk stock to 0 and 5tk stock to 3
    sum10 = 0; sum5 = 0; bad = 0; alldone = 1;
    for (int i = 0; i < 9; i++) begin
      run_txn(2'b10, 1'b0, 1'b1, n5, n10, nrel, bad_w, min_gap, wait_len, overlap, done);
      sum10 += n10; sum5 += n5; bad += bad_w + overlap + nrel;
      if (done == 0) alldone = 0;
    end
    for (int i = 0; i < 7; i++) begin
      run_txn(2'b01, 1'b0, 1'b1, n5, n10, nrel, bad_w, min_gap, wait_len, overlap, done);
      sum10 += n10; sum5 += n5; bad += bad_w + overlap + nrel;
      if (done == 0) alldone = 0;
    end
    chk("drain_done",  alldone, 1);
    chk("drain_n10",   sum10, 9);
    chk("drain_n5",    sum5, 7);
    chk("drain_bad",   bad, 0);
    chk("drain_inv10", u_bus.inv_10, 0);
    chk("drain_inv5",  u_bus.inv_5, 3);

    // R10 with no 10tk coins: two 5tk coins
    run_txn(2'b10, 1'b0, 1'b1, n5, n10, nrel, bad_w, min_gap, wait_len, overlap, done);
    chk("s2_done",   done, 1);
    chk("s2_n5",     n5, 2);
    chk("s2_n10",    n10, 0);
    chk("s2_gap",    (min_gap >= 2) ? 1 : 0, 1);
    chk("s2_bad",    bad_w + overlap, 0);
    chk("s2_inv5",   u_bus.inv_5, 1);

    run_txn(2'b01, 1'b0, 1'b1, n5, n10, nrel, bad_w, min_gap, wait_len, overlap, done);
    chk("r5_last_inv5", u_bus.inv_5, 0);

    // R5 with empty 5tk stock: fault one cycle after PLAN
    u_bus.req_valid = 1'b1; u_bus.cash_return = 2'b01; u_bus.purchase = 1'b0;
    tick();
    u_bus.req_valid = 1'b0;
    chk("s3_plan_fault", u_bus.fault, 0);
    tick();
    chk("s3_fault", u_bus.fault, 1);
    chk("s3_busy",  u_bus.busy, 0);
    flag = 1'b0;
    u_bus.req_valid = 1'b1; u_bus.cash_return = 2'b00; u_bus.purchase = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (u_bus.req_ready | u_bus.eject_5 | u_bus.eject_10 | u_bus.product_release | !u_bus.fault)
        flag = 1'b1;
    end
    u_bus.req_valid = 1'b0;
    chk("s3_held", flag, 0);
    chk("s3_inv5", u_bus.inv_5, 0);

    do_reset();
    chk("rst2_fault", u_bus.fault, 0);
    chk("rst2_inv5",  u_bus.inv_5, 10);
    chk("rst2_inv10", u_bus.inv_10, 10);

    // R0 + purchase: release only
    run_txn(2'b00, 1'b1, 1'b1, n5, n10, nrel, bad_w, min_gap, wait_len, overlap, done);
    chk("r0_done", done, 1);
    chk("r0_nrel", nrel, 1);
    chk("r0_ncoin", n5 + n10, 0);
    chk("r0_bad",  bad_w, 0);

    // Saturating refill
    u_bus.refill_valid = 1'b1; u_bus.refill_5 = 6'd63; u_bus.refill_10 = 6'd3;
    tick();
    u_bus.refill_valid = 1'b0;
    chk("refill_inv5",  u_bus.inv_5, 63);
    chk("refill_inv10", u_bus.inv_10, 13);

    // Refill ignored during EJECT, then reset mid-EJECT
    u_bus.req_valid = 1'b1; u_bus.cash_return = 2'b01; u_bus.purchase = 1'b0;
    tick();
    u_bus.req_valid = 1'b0;
    tick();
    chk("ej_hi", u_bus.eject_5, 1);
    u_bus.refill_valid = 1'b1; u_bus.refill_5 = 6'd1; u_bus.refill_10 = 6'd1;
    tick();
    u_bus.refill_valid = 1'b0;
    chk("ej_refill_inv5",  u_bus.inv_5, 63);
    chk("ej_refill_inv10", u_bus.inv_10, 13);
    rst = 1'b1;
    tick();
    chk("midrst_ej",    u_bus.eject_5, 0);
    chk("midrst_inv5",  u_bus.inv_5, 10);
    chk("midrst_inv10", u_bus.inv_10, 10);
    chk("midrst_ready", u_bus.req_ready, 1);
    rst = 1'b0;
    tick();

    // Sensor timeout
    run_txn(2'b01, 1'b0, 1'b0, n5, n10, nrel, bad_w, min_gap, wait_len, overlap, done);
    chk("to_done",  done, 1);
    chk("to_fault", u_bus.fault, 1);
    chk("to_n5",    n5, 1);
    chk("to_wait",  wait_len, 16);
    chk("to_inv5",  u_bus.inv_5, 10);

    // Illegal code
    do_reset();
    run_txn(2'b11, 1'b1, 1'b1, n5, n10, nrel, bad_w, min_gap, wait_len, overlap, done);
    chk("ill_done",  done, 1);
    chk("ill_fault", u_bus.fault, 1);
    chk("ill_pulse", n5 + n10 + nrel, 0);
    chk("ill_inv",   {u_bus.inv_5, u_bus.inv_10}, {6'd10, 6'd10});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
